// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state type for the pipeline controller
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {RUN, DWAIT, HALT} pipe_state_t;
endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter: counter that holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  // count up on en, stick at all-ones, clear on clr
  always_ff @(posedge clk)
    q <= clr ? '0 : (en && !(&q)) ? q + W'(1) : q;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: turns hazard/cache/redirect/halt events into PC and latch enables and flushes
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush_ls,
  input  logic             redirect_mem,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_mem,
  input  logic             dmemWEN_mem,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             imemREN,
  output logic             halt_out,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  pipe_state_t state, next;
  logic dbusy, live;
  assign dbusy = (dmemREN_mem | dmemWEN_mem) & ~dhit;
  assign live = state != HALT;
  assign imemREN = live;
  // priority chain: dcache wait, halt, redirect, load-use, icache miss, normal advance
  always_comb begin
    next = state;
    pc_en = 1'b0;
    {ifid_en, idex_en, exmem_en, memwb_en} = 4'b0000;
    {ifid_flush, idex_flush, exmem_flush, memwb_flush} = 4'b0000;
    if (!live) next = HALT;
    else if (dbusy) next = DWAIT;
    else if (halt_wb) next = HALT;
    else begin
      next = RUN;
      {ifid_en, idex_en, exmem_en, memwb_en} = flush_ls && !redirect_mem ? 4'b0111 : 4'b1111;
      pc_en = redirect_mem || (!flush_ls && ihit);
      {ifid_flush, idex_flush, exmem_flush, memwb_flush} =
        redirect_mem ? 4'b1110 : flush_ls ? 4'b0100 : !ihit ? 4'b1000 : 4'b0000;
    end
  end
  // state and sticky halt flag
  always_ff @(posedge CLK) begin
    state <= RST ? RUN : next;
    halt_out <= !RST && next == HALT;
  end
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(CLK), .clr(RST), .en(live && !pc_en), .q(stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush (
    .clk(CLK), .clr(RST),
    .en(ifid_flush | idex_flush | exmem_flush | memwb_flush), .q(flush_cnt)
  );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and random checks of pipeline_ctrl against a rule-level model
module tb_pipeline_ctrl;
  logic CLK = 1'b0;
  logic RST, flush_ls, redirect_mem, ihit, dhit, dmemREN_mem, dmemWEN_mem, halt_wb;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, imemREN, halt_out;
  logic [31:0] stall_cnt, flush_cnt;
  logic s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush, s_imemREN, s_halt_out;
  logic [3:0] s_stall_cnt, s_flush_cnt;
  int errors = 0, checks = 0;
  bit known = 0, halted = 0;
  longint st = 0, fc = 0;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .flush_ls(flush_ls), .redirect_mem(redirect_mem), .ihit(ihit),
    .dhit(dhit), .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem), .halt_wb(halt_wb),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .imemREN(imemREN),
    .halt_out(halt_out), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .flush_ls(flush_ls), .redirect_mem(redirect_mem), .ihit(ihit),
    .dhit(dhit), .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem), .halt_wb(halt_wb),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
    .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .exmem_flush(s_exmem_flush), .memwb_flush(s_memwb_flush), .imemREN(s_imemREN),
    .halt_out(s_halt_out), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // expected {pc_en, ifid/idex/exmem/memwb en, ifid/idex/exmem/memwb flush, imemREN}
  function automatic logic [9:0] ref_out(input bit h, input logic fl, rd, ih, busy, hw);
    if (h) return 10'b0_0000_0000_0;
    if (busy || hw) return 10'b0_0000_0000_1;
    if (rd) return 10'b1_1111_1110_1;
    if (fl) return 10'b0_0111_0100_1;
    if (!ih) return 10'b0_1111_1000_1;
    return 10'b1_1111_0000_1;
  endfunction

  // every-cycle comparison against the model, then advance the model across the next edge
  always @(negedge CLK) begin
    logic [9:0] e;
    logic busy;
    busy = (dmemREN_mem | dmemWEN_mem) & ~dhit;
    e = ref_out(halted, flush_ls, redirect_mem, ihit, busy, halt_wb);
    if (known) begin
      chk("outs", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
                   exmem_flush, memwb_flush, imemREN}, e);
      chk("outs4", {s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en, s_ifid_flush,
                    s_idex_flush, s_exmem_flush, s_memwb_flush, s_imemREN}, e);
      chk("halt_out", {halt_out, s_halt_out}, {halted, halted});
      chk("stall_cnt", stall_cnt, st);
      chk("flush_cnt", flush_cnt, fc);
      chk("stall_cnt4", s_stall_cnt, st > 15 ? 15 : st);
      chk("flush_cnt4", s_flush_cnt, fc > 15 ? 15 : fc);
    end
    if (RST) begin
      known = 1; halted = 0; st = 0; fc = 0;
    end else if (known && !halted) begin
      if (!e[9]) st++;
      if (|e[4:1]) fc++;
      halted = !busy && halt_wb;
    end
  end

  initial begin
    RST = 1; ihit = 1; flush_ls = 0; redirect_mem = 0; dhit = 0;
    dmemREN_mem = 0; dmemWEN_mem = 0; halt_wb = 0;
    step(); step();
    RST = 0;
    #2;
    chk("t1_counts", {halt_out, stall_cnt, flush_cnt}, 0);
    chk("t1_run", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);
    chk("t1_noflush", {ifid_flush, idex_flush, exmem_flush, memwb_flush}, 4'b0000);
    step();
    dmemREN_mem = 1; dhit = 0;
    for (int i = 0; i < 3; i++) begin
      #2 chk("t2_wait", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b00000);
      step();
    end
    dhit = 1;
    #2 chk("t2_done", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);
    chk("t2_stall", stall_cnt, 3);
    step();
    dmemREN_mem = 0; dhit = 0; flush_ls = 1;
    #2 chk("t3_ls", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, idex_flush}, 6'b001111);
    step();
    flush_ls = 0;
    #2 chk("t3_flush", flush_cnt, 1);
    step();
    redirect_mem = 1; flush_ls = 1; ihit = 0;
    #2 chk("t4_redir", {pc_en, ifid_flush, idex_flush, exmem_flush, memwb_flush}, 5'b11110);
    step();
    redirect_mem = 0; flush_ls = 0; ihit = 1; halt_wb = 1;
    #2 chk("t4_flush", flush_cnt, 2);
    chk("t5_halting", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, halt_out}, 6'b000000);
    step();
    halt_wb = 0;
    #2 chk("t5_halted", {halt_out, imemREN, pc_en, ifid_en, memwb_en}, 5'b10000);
    for (int i = 0; i < 6; i++) begin
      ihit = i[0];
      step();
    end
    #2 chk("t5_frozen", {stall_cnt, flush_cnt}, {32'd5, 32'd2});
    RST = 1;
    step();
    RST = 0; ihit = 0;
    #2 chk("t5_reset", {halt_out, imemREN}, 2'b01);
    repeat (20) step();
    #2 chk("t6_sat4", s_stall_cnt, 15);
    chk("t6_full", stall_cnt, 20);
    for (int i = 0; i < 3000; i++) begin
      RST = $urandom_range(99) == 0;
      flush_ls = $urandom_range(3) == 0;
      redirect_mem = $urandom_range(5) == 0;
      ihit = $urandom_range(3) != 0;
      dmemREN_mem = $urandom_range(3) == 0;
      dmemWEN_mem = $urandom_range(5) == 0;
      dhit = 1'($urandom_range(1));
      halt_wb = $urandom_range(63) == 0;
      step();
    end
    @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
